msrv32_imem_ahb_slave: RTL

AHB-Lite read-only instruction memory responder for the msrv32 core. It is the slave end of the instruction-fetch bus: it accepts the fetch address from the PC/fetch stage and returns the instruction word through hrdata/hready. It supports programmable wait states and the two-cycle AHB ERROR response for misaligned, out-of-range and write transfers. A side load port lets the testbench or boot logic preload the memory.

---
 rtl/msrv32_imem_ahb_slave.sv | 114 +++++++++++
 1 files changed

// File: rtl/msrv32_imem_ahb_slave.sv
// AHB-Lite read-only instruction memory for the msrv32 fetch path.
// Programmable wait states, two-cycle ERROR response and a side preload port.
module msrv32_imem_ahb_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 0,
    localparam int         AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          ms_riscv32_mp_clk_in,
    input  logic          ms_riscv32_mp_rst_n_in,
    input  logic          hsel_in,
    input  logic [1:0]    htrans_in,
    input  logic [31:0]   haddr_in,
    input  logic          hwrite_in,
    output logic          hready_out,
    output logic          hresp_out,
    output logic [31:0]   hrdata_out,
    input  logic          load_en_in,
    input  logic [AW-1:0] load_addr_in,
    input  logic [31:0]   load_data_in
);

    localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) * 33'd4;
    localparam bit          ZERO_WAIT = (WAIT_STATES == 0);
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {S_OKAY, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [31:0]  hrdata_q;
    logic [31:0]  rd_latch_q;
    logic [31:0]  mem [DEPTH_WORDS];

    logic         accept;
    logic         is_err;
    logic         good_rd;
    logic [31:0]  offset;
    logic [AW-1:0] idx;
    logic         unused_htrans;

    assign unused_htrans = htrans_in[0];

    // Addresses below BASE_ADDR wrap to huge offsets and fall out of range.
    assign offset  = haddr_in - BASE_ADDR;
    assign idx     = offset[AW+1:2];
    assign accept  = hsel_in & htrans_in[1] & hready_out;
    assign is_err  = hwrite_in | (|haddr_in[1:0]) | ({1'b0, offset} >= SPAN);
    assign good_rd = accept & ~is_err;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hready_out = 1'b1;
        hresp_out  = 1'b0;
        case (state_q)
            S_OKAY, S_ERR2: begin
                hresp_out = (state_q == S_ERR2);
                state_d   = S_OKAY;
                if (accept) begin
                    if (is_err) begin
                        state_d = S_ERR1;
                    end else if (!ZERO_WAIT) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                hready_out = 1'b0;
                if (cnt_q == 4'd0) begin
                    state_d = S_OKAY;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ERR1: begin
                hready_out = 1'b0;
                hresp_out  = 1'b1;
                state_d    = S_ERR2;
            end
            default: state_d = S_OKAY;
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state_q  <= S_OKAY;
            cnt_q    <= 4'd0;
            hrdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (ZERO_WAIT && good_rd) begin
                hrdata_q <= mem[idx];
            end else if (state_q == S_WAIT && cnt_q == 4'd0) begin
                hrdata_q <= rd_latch_q;
            end
        end
    end

    // Fetch reads see pre-load contents when a load hits the same word on the same edge.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (load_en_in) begin
            mem[load_addr_in] <= load_data_in;
        end
        if (good_rd) begin
            rd_latch_q <= mem[idx];
        end
    end

    assign hrdata_out = hrdata_q;

endmodule
